ins_fetch_unit: RTL
===================

# ins_fetch_unit

Instruction fetch unit on the IRAM side of the fetch path. It owns the program counter (PC) and issues synchronous reads to the single-port IRAM. It returns each instruction byte with a one-cycle valid pulse, which the instruction-latching stage captures when the MIR fetch signal is high. It also provides a streaming program-load mode that writes a byte stream into IRAM before execution.

## Interface
Parameters:
- ADDR_W, 8, IRAM address width; the PC and write pointer wrap modulo 2^ADDR_W
- INS_W, 8, instruction width
- PROG_START, 0, PC value after reset and after every completed program load
- HALT_OP, 8'hFF, opcode that stops fetching after it is delivered

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- prog_mode  in  1  request to enter load mode
- prog_valid  in  1  prog_data is valid this cycle
- prog_data  in  INS_W  byte to write to IRAM
- prog_last  in  1  marks the final byte of the stream
- prog_ready  out  1  high in S_PROG; a byte is accepted when prog_valid && prog_ready
- prog_done  out  1  one-cycle pulse after the load completes
- fetch  in  1  MIR fetch request
- jump  in  1  load the PC from jump_addr
- jump_addr  in  ADDR_W  jump target
- iram_en  out  1  IRAM read enable
- iram_we  out  1  IRAM write enable
- iram_addr  out  ADDR_W  IRAM address
- iram_din  out  INS_W  IRAM write data
- iram_dout  in  INS_W  IRAM read data; valid one cycle after iram_en
- ins_out  out  INS_W  last fetched instruction; holds its value between fetches
- ins_valid  out  1  one-cycle pulse when ins_out updates
- pc  out  ADDR_W  current PC
- busy  out  1  high in S_REQ, S_WAIT and S_PROG

## Operation
- **States:** S_IDLE, S_PROG, S_REQ, S_WAIT, S_HALT.
- **Reset values:**
  - state = S_IDLE; pc = PROG_START; write pointer = 0.
  - ins_out = 0; ins_valid, prog_done, prog_ready, busy = 0.
  - iram_en, iram_we = 0; iram_addr and iram_din = 0.
  - IRAM contents are untouched by reset.
- **S_IDLE:**
  - If prog_mode is high, go to S_PROG and clear the write pointer. prog_mode has priority over fetch.
  - Otherwise, if fetch is high, go to S_REQ.
- **S_PROG:**
  - On each accepted byte: iram_we = 1, iram_addr = write pointer, iram_din = prog_data; the pointer then increments.
  - If the accepted byte has prog_last set, or the pointer was 2^ADDR_W-1: pulse prog_done, set pc = PROG_START, go to S_IDLE.
  - If prog_mode drops before completion: go to S_IDLE with no prog_done pulse and no PC change. Bytes already written stay in IRAM.
- **S_REQ:** iram_en = 1 and iram_addr = pc. On exit, pc increments (wrapping). Next state is S_WAIT.
- **S_WAIT:**
  - Capture ins_out <= iram_dout and pulse ins_valid in the following cycle.
  - If the captured byte equals HALT_OP, go to S_HALT; otherwise go to S_IDLE.
- **S_HALT:** Ignores fetch. Leaves only on rst, or on prog_mode, which goes to S_PROG.
- **Jump:**
  - Accepted in S_IDLE, S_REQ, S_WAIT and S_HALT; ignored in S_PROG.
  - pc <= jump_addr at the next edge. A jump overrides the increment on S_REQ exit.
  - A jump does not abort a fetch already in flight.
- **Fetch outside S_IDLE:** ignored; there is no queue.
- **iram_we and iram_en:** never high in the same cycle.

## Timing
- **Fetch latency:** fetch is sampled high in S_IDLE at edge 0. iram_en is high in cycle 1 and the state is S_WAIT in cycle 2. ins_valid is high in cycle 3 with ins_out = IRAM[pc0].
- **Back-to-back fetch:** fetch held high gives one instruction every 3 cycles. The ins_valid cycle is already S_IDLE, so fetch is accepted in that cycle.
- **Load throughput:** one byte per cycle while prog_valid is held high. prog_done is high the cycle after the last byte is accepted.
- **prog_mode during a fetch:** if prog_mode rises in S_REQ or S_WAIT, the fetch completes, including its ins_valid pulse. S_PROG is entered from S_IDLE.
- **Reset mid-operation:** reset in any state returns to S_IDLE with all outputs at their reset values on the next edge. A write in flight in that cycle is suppressed.

## Structure
- **Shared package idp_pkg:**
  - fetch_state_t enum.
  - Default ADDR_W, INS_W and HALT_OP constants, reused by the control store and the instruction-latching stage.
- **Sub-module prog_counter:**
  - Holds the ADDR_W register with synchronous reset to PROG_START.
  - Controls: inc, load (jump, priority over inc), rst_to_start (load done).
- **Top level:** the FSM, load pointer and IRAM port muxing live in ins_fetch_unit.

## Test plan
- **Load and fetch:**
  - Stream 0x11, 0x22, 0x33 with last set on 0x33, then fetch three times.
  - Required: prog_done is high for one cycle; ins_out reads 0x11, 0x22, 0x33, with each ins_valid 3 cycles after its fetch; pc = 3.
- **Jump priority:**
  - Assert jump with jump_addr = 0x40 during S_REQ while fetching address 5.
  - Required: ins_out = IRAM[5]; pc = 0x40, not 6.
- **Halt:**
  - Load 0x01, 0xFF, 0x02, then hold fetch high.
  - Required: 0x01 and 0xFF are delivered; no further ins_valid; pc = 2; busy = 0.
- **Aborted load:**
  - Drop prog_mode after 2 bytes.
  - Required: no prog_done pulse; pc unchanged; those 2 bytes are readable at addresses 0 and 1.
- **Wrap-around:**
  - With ADDR_W = 4, stream 16 bytes without last.
  - Required: prog_done fires after the 16th byte. Then 17 fetches return byte 0 on the 17th fetch, because pc wraps 15 -> 0.
- **Reset mid-fetch:**
  - Assert rst in S_WAIT.
  - Required: no ins_valid; ins_out = 0; pc = PROG_START; state = S_IDLE.

Source files
------------

// File: rtl/idp_pkg.sv
// Shared definitions for the instruction datapath: fetch FSM states and
// default widths/opcodes reused by the control store and latching stage.
package idp_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_INS_W   = 8;
    localparam logic [7:0]  DEF_HALT_OP = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_REQ,
        S_WAIT,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/ins_fetch_unit_prog_counter.sv
// Program counter register: reset/load-complete restart, jump load, increment.
module prog_counter #(
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] PROG_START = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_to_start,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    // Restart beats jump, jump beats increment; increment wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || rst_to_start) begin
            pc <= PROG_START;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues synchronous IRAM reads, returns
// each instruction with a one-cycle valid pulse, and streams program loads.
module ins_fetch_unit
    import idp_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       INS_W      = DEF_INS_W,
    parameter logic [ADDR_W-1:0] PROG_START = '0,
    parameter logic [INS_W-1:0]  HALT_OP    = INS_W'(DEF_HALT_OP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [INS_W-1:0]  prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_done,
    input  logic              fetch,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              iram_en,
    output logic              iram_we,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [INS_W-1:0]  iram_din,
    input  logic [INS_W-1:0]  iram_dout,
    output logic [INS_W-1:0]  ins_out,
    output logic              ins_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] wptr;
    logic              accept;
    logic              load_end;

    // A byte is taken only in S_PROG; gating with rst suppresses a write in the reset cycle.
    assign accept     = (state == S_PROG) && prog_valid && !rst;
    assign load_end   = accept && (prog_last || (wptr == '1));
    assign prog_ready = (state == S_PROG) && !rst;
    assign busy       = (state == S_REQ) || (state == S_WAIT) || (state == S_PROG);

    prog_counter #(
        .ADDR_W     (ADDR_W),
        .PROG_START (PROG_START)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .rst_to_start (load_end),
        .load         (jump && (state != S_PROG)),
        .inc          (state == S_REQ),
        .load_addr    (jump_addr),
        .pc           (pc)
    );

    // Next-state selection; a load completion wins over prog_mode dropping.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (prog_mode) begin
                    state_next = S_PROG;
                end else if (fetch) begin
                    state_next = S_REQ;
                end
            end
            S_PROG: begin
                if (load_end || !prog_mode) begin
                    state_next = S_IDLE;
                end
            end
            S_REQ:  state_next = S_WAIT;
            S_WAIT: state_next = (iram_dout == HALT_OP) ? S_HALT : S_IDLE;
            S_HALT: begin
                if (prog_mode) begin
                    state_next = S_PROG;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // IRAM port mux: writes in S_PROG, reads in S_REQ, never both.
    always_comb begin
        iram_en   = 1'b0;
        iram_we   = 1'b0;
        iram_addr = '0;
        iram_din  = '0;
        if (accept) begin
            iram_we   = 1'b1;
            iram_addr = wptr;
            iram_din  = prog_data;
        end else if ((state == S_REQ) && !rst) begin
            iram_en   = 1'b1;
            iram_addr = pc;
        end
    end

    // State, load pointer, captured instruction and the two pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wptr      <= '0;
            ins_out   <= '0;
            ins_valid <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            state     <= state_next;
            ins_valid <= (state == S_WAIT);
            prog_done <= load_end;
            if (state == S_WAIT) begin
                ins_out <= iram_dout;
            end
            if ((state_next == S_PROG) && (state != S_PROG)) begin
                wptr <= '0;
            end else if (accept) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

endmodule
